lfsr_seq_checker: RTL and testbench

//  Downstream consumer of the LSER/LFSR counter output Q[1:N].

---
 rtl/lfsr_pkg.sv | 21 ++
 rtl/lfsr_period_meter.sv | 55 +++++
 rtl/lfsr_seq_checker.sv | 125 ++++++++++++
 tb/tb_lfsr_seq_checker.sv | 185 ++++++++++++++++++
 4 files changed

// File: rtl/lfsr_pkg.sv
// Shared types and the reference next-state function for the LFSR sequence checker.
package lfsr_pkg;

  typedef enum logic {
    SEARCH = 1'b0,
    LOCKED = 1'b1
  } state_e;

  localparam int MAX_W = 32;

  // Bit 0 holds Q[N] and bit n-1 holds Q[1]; the state shifts toward Q[N] and feedback enters at Q[1].
  function automatic logic [MAX_W-1:0] lfsr_next(input logic [MAX_W-1:0] p,
                                                 input int n,
                                                 input int tap);
    logic [MAX_W-1:0] r;
    r = p >> 1;
    r[n-1] = p[0] ^ p[n-tap];
    return r;
  endfunction

endpackage

// File: rtl/lfsr_period_meter.sv
// Measures the distance, in valid samples, between successive SEED states while locked.
module lfsr_period_meter
  import lfsr_pkg::*;
#(
  parameter int          N    = 3,
  parameter int unsigned SEED = 1,
  parameter int          P_W  = N + 1
) (
  input  logic           clk,
  input  logic           reset,
  input  logic           active_i,
  input  logic           valid_i,
  input  logic [N-1:0]   q_i,
  output logic [P_W-1:0] period_o,
  output logic           period_valid_o
);

  localparam logic [N-1:0] SEED_V = N'(SEED);

  logic           armed_q;
  logic [P_W-1:0] cnt_q;
  logic [P_W-1:0] period_q;
  logic           period_valid_q;

  always_ff @(posedge clk) begin
    if (reset) begin
      armed_q        <= 1'b0;
      cnt_q          <= '0;
      period_q       <= '0;
      period_valid_q <= 1'b0;
    end else begin
      period_valid_q <= 1'b0;
      // Dropping out of lock discards any partial measurement; period keeps the last result.
      if (!active_i) begin
        armed_q <= 1'b0;
        cnt_q   <= '0;
      end else if (valid_i) begin
        if (q_i == SEED_V) begin
          if (armed_q) begin
            period_q       <= cnt_q + P_W'(1);
            period_valid_q <= 1'b1;
          end
          armed_q <= 1'b1;
          cnt_q   <= '0;
        end else if (armed_q && (cnt_q != '1)) begin
          cnt_q <= cnt_q + P_W'(1);
        end
      end
    end
  end

  assign period_o       = period_q;
  assign period_valid_o = period_valid_q;

endmodule

// File: rtl/lfsr_seq_checker.sv
// Checks an LFSR counter stream against its expected next state, tracks lock,
// counts sequence errors, flags the all-zero lock-up state and measures period.
module lfsr_seq_checker
  import lfsr_pkg::*;
#(
  parameter int          N          = 3,
  parameter int          TAP        = 2,
  parameter int unsigned SEED       = 1,
  parameter int          LOCK_CNT   = 4,
  parameter int          UNLOCK_CNT = 2,
  parameter int          CNT_W      = 8,
  parameter int          P_W        = N + 1
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             in_valid,
  input  logic [1:N]       q_in,
  output logic             locked,
  output logic             seq_err,
  output logic             lockup,
  output logic [CNT_W-1:0] err_count,
  output logic [P_W-1:0]   period,
  output logic             period_valid
);

  localparam int GW = $clog2(LOCK_CNT + 1);
  localparam int BW = $clog2(UNLOCK_CNT + 1);
  localparam logic [GW-1:0] GOOD_TC = GW'(LOCK_CNT - 1);
  localparam logic [BW-1:0] BAD_TC  = BW'(UNLOCK_CNT - 1);

  logic [N-1:0]     q_v;
  logic [N-1:0]     prev_q;
  logic             prev_vld_q;
  state_e           state_q;
  logic [GW-1:0]    good_q;
  logic [BW-1:0]    bad_q;
  logic             seq_err_q;
  logic             lockup_q;
  logic [CNT_W-1:0] err_q;
  logic             q_zero;
  logic             match;

  assign q_v    = q_in;
  assign q_zero = (q_v == '0);
  assign match  = prev_vld_q &&
                  (MAX_W'(q_v) == lfsr_next(MAX_W'(prev_q), N, TAP));

  always_ff @(posedge clk) begin
    if (reset) begin
      prev_q     <= '0;
      prev_vld_q <= 1'b0;
      state_q    <= SEARCH;
      good_q     <= '0;
      bad_q      <= '0;
      seq_err_q  <= 1'b0;
      lockup_q   <= 1'b0;
      err_q      <= '0;
    end else begin
      seq_err_q <= 1'b0;
      if (in_valid) begin
        prev_q <= q_v;
        // All-zero is the LFSR's dead state: abandon lock and restart acquisition from scratch.
        if (q_zero) begin
          lockup_q   <= 1'b1;
          state_q    <= SEARCH;
          good_q     <= '0;
          prev_vld_q <= 1'b0;
        end else begin
          lockup_q   <= 1'b0;
          prev_vld_q <= 1'b1;
          case (state_q)
            SEARCH: begin
              if (prev_vld_q) begin
                if (!match) begin
                  good_q <= '0;
                end else if (good_q == GOOD_TC) begin
                  state_q <= LOCKED;
                  good_q  <= '0;
                  bad_q   <= '0;
                end else begin
                  good_q <= good_q + GW'(1);
                end
              end
            end
            LOCKED: begin
              if (match) begin
                bad_q <= '0;
              end else begin
                seq_err_q <= 1'b1;
                if (err_q != '1) err_q <= err_q + CNT_W'(1);
                if (bad_q == BAD_TC) begin
                  state_q <= SEARCH;
                  good_q  <= '0;
                end else begin
                  bad_q <= bad_q + BW'(1);
                end
              end
            end
            default: state_q <= SEARCH;
          endcase
        end
      end
    end
  end

  lfsr_period_meter #(
    .N    (N),
    .SEED (SEED),
    .P_W  (P_W)
  ) u_period_meter (
    .clk            (clk),
    .reset          (reset),
    .active_i       (state_q == LOCKED),
    .valid_i        (in_valid && !q_zero),
    .q_i            (q_v),
    .period_o       (period),
    .period_valid_o (period_valid)
  );

  assign locked    = (state_q == LOCKED);
  assign seq_err   = seq_err_q;
  assign lockup    = lockup_q;
  assign err_count = err_q;

endmodule

// File: tb/tb_lfsr_seq_checker.sv
// Vector table plus scoreboard bench for lfsr_seq_checker (N=3, TAP=2, SEED=001).
module tb_lfsr_seq_checker;

  logic       clk = 1'b0;
  logic       reset;
  logic       in_valid;
  logic [1:3] q_in;
  logic       locked;
  logic       seq_err;
  logic       lockup;
  logic [7:0] err_count;
  logic [3:0] period;
  logic       period_valid;

  int checks   = 0;
  int failures = 0;

  typedef struct {
    logic       rst;
    logic       vld;
    logic [2:0] q;
    logic       locked;
    logic       seq_err;
    logic       lockup;
    logic       pv;
    logic [7:0] err;
    logic [3:0] period;
  } vec_t;

  vec_t tbl[$];
  vec_t sb[$];
  logic [2:0] seqv [7];

  always #5 clk = ~clk;

  lfsr_seq_checker #(
    .N(3), .TAP(2), .SEED(1), .LOCK_CNT(4), .UNLOCK_CNT(2), .CNT_W(8), .P_W(4)
  ) dut (
    .clk          (clk),
    .reset        (reset),
    .in_valid     (in_valid),
    .q_in         (q_in),
    .locked       (locked),
    .seq_err      (seq_err),
    .lockup       (lockup),
    .err_count    (err_count),
    .period       (period),
    .period_valid (period_valid)
  );

  task automatic add(input logic rst, input logic vld, input logic [2:0] q,
                     input logic l, input logic se, input logic lu, input logic pv,
                     input logic [7:0] err, input logic [3:0] per);
    vec_t v;
    v.rst = rst; v.vld = vld; v.q = q;
    v.locked = l; v.seq_err = se; v.lockup = lu; v.pv = pv;
    v.err = err; v.period = per;
    tbl.push_back(v);
  endtask

  task automatic step(input vec_t v, input string tag, input int idx);
    vec_t e;
    logic [15:0] got;
    logic [15:0] want;
    @(negedge clk);
    reset    = v.rst;
    in_valid = v.vld;
    q_in     = v.q;
    sb.push_back(v);
    @(posedge clk);
    #1;
    e = sb.pop_front();
    got  = {locked, seq_err, lockup, period_valid, err_count, period};
    want = {e.locked, e.seq_err, e.lockup, e.pv, e.err, e.period};
    checks++;
    if (got !== want) begin
      failures++;
      $display("FAIL %s[%0d] q=%b: got locked=%b seq_err=%b lockup=%b pv=%b err=%0d period=%0d, required locked=%b seq_err=%b lockup=%b pv=%b err=%0d period=%0d",
               tag, idx, e.q, locked, seq_err, lockup, period_valid, err_count, period,
               e.locked, e.seq_err, e.lockup, e.pv, e.err, e.period);
    end
  endtask

  initial begin
    int i;
    int err_e;
    vec_t v;

    reset = 1'b1; in_valid = 1'b0; q_in = 3'b000;
    seqv[0] = 3'b001; seqv[1] = 3'b100; seqv[2] = 3'b010; seqv[3] = 3'b101;
    seqv[4] = 3'b110; seqv[5] = 3'b111; seqv[6] = 3'b011;

    // rst vld q      L  SE LU PV err per
    add(1, 0, 3'b000, 0, 0, 0, 0, 0, 0);
    add(1, 0, 3'b000, 0, 0, 0, 0, 0, 0);
    // legal sequence: lock on the 5th valid sample, period 7 on the 2nd SEED
    add(0, 1, 3'b001, 0, 0, 0, 0, 0, 0);
    add(0, 1, 3'b100, 0, 0, 0, 0, 0, 0);
    add(0, 1, 3'b010, 0, 0, 0, 0, 0, 0);
    add(0, 1, 3'b101, 0, 0, 0, 0, 0, 0);
    add(0, 1, 3'b110, 1, 0, 0, 0, 0, 0);
    add(0, 1, 3'b111, 1, 0, 0, 0, 0, 0);
    add(0, 1, 3'b011, 1, 0, 0, 0, 0, 0);
    add(0, 1, 3'b001, 1, 0, 0, 0, 0, 0);
    add(0, 1, 3'b100, 1, 0, 0, 0, 0, 0);
    add(0, 1, 3'b010, 1, 0, 0, 0, 0, 0);
    add(0, 1, 3'b101, 1, 0, 0, 0, 0, 0);
    add(0, 1, 3'b110, 1, 0, 0, 0, 0, 0);
    add(0, 1, 3'b111, 1, 0, 0, 0, 0, 0);
    add(0, 1, 3'b011, 1, 0, 0, 0, 0, 0);
    add(0, 1, 3'b001, 1, 0, 0, 1, 0, 7);
    add(0, 1, 3'b100, 1, 0, 0, 0, 0, 7);
    // gaps in in_valid, including an invalid all-zero q_in
    add(0, 0, 3'b011, 1, 0, 0, 0, 0, 7);
    add(0, 0, 3'b000, 1, 0, 0, 0, 0, 7);
    add(0, 1, 3'b010, 1, 0, 0, 0, 0, 7);
    add(0, 0, 3'b111, 1, 0, 0, 0, 0, 7);
    add(0, 1, 3'b101, 1, 0, 0, 0, 0, 7);
    add(0, 0, 3'b101, 1, 0, 0, 0, 0, 7);
    add(0, 1, 3'b110, 1, 0, 0, 0, 0, 7);
    add(0, 1, 3'b111, 1, 0, 0, 0, 0, 7);
    add(0, 0, 3'b000, 1, 0, 0, 0, 0, 7);
    add(0, 1, 3'b011, 1, 0, 0, 0, 0, 7);
    add(0, 1, 3'b001, 1, 0, 0, 1, 0, 7);
    // two wrong samples drop lock, then relock
    add(0, 1, 3'b100, 1, 0, 0, 0, 0, 7);
    add(0, 1, 3'b110, 1, 1, 0, 0, 1, 7);
    add(0, 1, 3'b101, 0, 1, 0, 0, 2, 7);
    add(0, 1, 3'b110, 0, 0, 0, 0, 2, 7);
    add(0, 1, 3'b111, 0, 0, 0, 0, 2, 7);
    add(0, 1, 3'b011, 0, 0, 0, 0, 2, 7);
    add(0, 1, 3'b001, 1, 0, 0, 0, 2, 7);
    add(0, 1, 3'b100, 1, 0, 0, 0, 2, 7);
    // all-zero lock-up while locked, then recovery
    add(0, 1, 3'b000, 0, 0, 1, 0, 2, 7);
    add(0, 1, 3'b001, 0, 0, 0, 0, 2, 7);
    add(0, 1, 3'b100, 0, 0, 0, 0, 2, 7);
    add(0, 1, 3'b010, 0, 0, 0, 0, 2, 7);
    add(0, 1, 3'b101, 0, 0, 0, 0, 2, 7);
    add(0, 1, 3'b110, 1, 0, 0, 0, 2, 7);
    add(0, 1, 3'b111, 1, 0, 0, 0, 2, 7);
    // mid-sequence reset wins over a valid sample
    add(1, 1, 3'b011, 0, 0, 0, 0, 0, 0);
    add(0, 1, 3'b001, 0, 0, 0, 0, 0, 0);
    add(0, 1, 3'b100, 0, 0, 0, 0, 0, 0);
    add(0, 1, 3'b010, 0, 0, 0, 0, 0, 0);
    add(0, 1, 3'b101, 0, 0, 0, 0, 0, 0);
    add(0, 1, 3'b110, 1, 0, 0, 0, 0, 0);

    for (int k = 0; k < tbl.size(); k++) step(tbl[k], "vec", k);

    // error counter saturation: two errors per round, relock with four matches
    i = 4;
    err_e = 0;
    for (int r = 0; r < 130; r++) begin
      v.rst = 1'b0; v.vld = 1'b1; v.lockup = 1'b0; v.pv = 1'b0; v.period = 4'd0;
      v.q = seqv[(i + 3) % 7]; v.locked = 1'b1; v.seq_err = 1'b1;
      err_e = (err_e == 255) ? 255 : err_e + 1;
      v.err = 8'(err_e);
      step(v, "sat_err1", r);
      v.q = seqv[(i + 6) % 7]; v.locked = 1'b0;
      err_e = (err_e == 255) ? 255 : err_e + 1;
      v.err = 8'(err_e);
      step(v, "sat_err2", r);
      v.seq_err = 1'b0;
      for (int m = 7; m <= 10; m++) begin
        v.q = seqv[(i + m) % 7];
        v.locked = (m == 10);
        step(v, "sat_relock", r);
      end
      i = (i + 10) % 7;
    end

    @(negedge clk);
    checks++;
    if (err_count !== 8'd255) begin
      failures++;
      $display("FAIL err_sat_final: got %0d, required 255", err_count);
    end

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
